vme_master_arbiter: RTL and testbench
=====================================

Name: vme_master_arbiter

Overview:
- Shares the single VME master command port between two requesters: port A (test controller) and port B (slow-control / configuration path).
- Round-robin arbitration; latches the granted command and issues it as a one-cycle vme_cmd strobe.
- Waits for the master's completion strobe vme_cmd_rd, returns read data plus a one-cycle done to the owner.
- A watchdog aborts transactions the master never completes.

Parameters:
- TIMEOUT_CYC, 1023, WAIT-state cycles before abort; range 1..1023.
- TO_W, 10, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- sw_reset  in  1  synchronous, active-high reset.
- req_a  in  1  port A request; held high until done_a.
- addr_a  in  23  port A VME address [23:1].
- wr_a  in  1  port A write command.
- rd_a  in  1  port A read command.
- wdata_a  in  16  port A write data.
- grant_a  out  1  port A owns the master, ISSUE through DONE.
- done_a  out  1  one-cycle completion pulse to A.
- req_b, addr_b, wr_b, rd_b, wdata_b, grant_b, done_b  same as port A, for port B.
- rd_data  out  16  read data of last completed transaction, shared.
- timeout_err  out  1  qualifies done_x: 1 = aborted by watchdog.
- busy  out  1  high in any state except IDLE.
- spurious  out  1  sticky; vme_cmd_rd seen outside WAIT; cleared only by reset.
- vme_cmd  out  1  one-cycle command strobe to the VME master.
- vme_addr  out  23  latched address [23:1].
- vme_wr  out  1  latched write flag.
- vme_rd  out  1  latched read flag.
- vme_wr_data  out  16  latched write data.
- vme_cmd_rd  in  1  master completion pulse.
- vme_rd_data  in  16  master read data, valid with vme_cmd_rd.

Behaviour:
- Reset: when sw_reset is sampled high, all outputs go to 0, the state goes to IDLE, last_owner goes to B (A wins the first tie), and the timeout counter goes to 0. Reset mid-transaction aborts it silently: no done pulse, grant drops next cycle.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No requests: stay in IDLE.
  - Only one port requesting: grant that port.
  - Both requesting: grant the port that is not last_owner.
  - On grant: latch that port's addr/wr/rd/wdata into vme_addr/vme_wr/vme_rd/vme_wr_data, set grant_x, update last_owner, go to ISSUE.
- ISSUE:
  - vme_cmd = 1 for exactly this cycle; clear the timeout counter; go to WAIT.
  - The master never completes in the same cycle as vme_cmd, so vme_cmd_rd in ISSUE sets spurious and is otherwise ignored.
- WAIT:
  - vme_cmd_rd = 1: capture rd_data <= vme_rd_data if vme_rd = 1, else hold rd_data; timeout_err <= 0; go to DONE.
  - Else, counter == TIMEOUT_CYC-1: rd_data <= 0, timeout_err <= 1, go to DONE.
  - Else: counter increments.
  - vme_cmd_rd in the final timeout cycle counts as a completion: completion wins over timeout.
- DONE:
  - done_x = 1 for this single cycle for the owner; clear vme_cmd latches' strobe; go to IDLE.
  - grant_x falls on entry to IDLE.
  - vme_addr/vme_wr/vme_rd/vme_wr_data hold their values until the next grant.
- Requester rule: deassert req on the edge that samples done_x high. A req still high in the IDLE cycle after DONE is treated as a new request; no minimum gap is imposed.
- Latency, no contention: req to vme_cmd = 2 edges (IDLE sample, ISSUE). vme_cmd_rd to done_x = 1 edge.
- Back-to-back requests from the same port with the other port idle are served consecutively, with no starvation penalty.
- Command fields on a non-granted port are don't-care. Changing the granted port's fields after grant has no effect.
- wr_x and rd_x both 1 or both 0: forwarded unchanged. Checking them is the master's job.
- spurious is also set by vme_cmd_rd in IDLE or DONE.
- timeout_err and rd_data hold until the next DONE.

Test Plan:
- Single A read: req_a with addr 23'h00_7000, rd=1; master returns 16'hBEEF 5 cycles after vme_cmd. Required: vme_cmd one cycle, 2 edges after req; done_a one cycle later; rd_data = BEEF; timeout_err = 0; grant_b never high.
- Simultaneous requests after reset: req_a and req_b rise together, each a write. Required: A served first, then B. Second contention round: B wins if B was not last owner, otherwise alternates A, B, A, B across 4 transactions.
- Timeout, TIMEOUT_CYC = 8: A read, master silent. Required: done_a exactly 8 WAIT cycles after ISSUE; timeout_err = 1; rd_data = 0. A following B transaction completes normally with timeout_err = 0.
- Completion on the last timeout cycle (TIMEOUT_CYC = 8, vme_cmd_rd in WAIT cycle 8, data 16'h1234). Required: timeout_err = 0; rd_data = 1234.
- sw_reset during WAIT. Required: outputs 0 next cycle; no done pulse; next req_a is served from IDLE normally.
- vme_cmd_rd pulse while IDLE. Required: spurious = 1 and stays set; state and rd_data unchanged; cleared only by sw_reset.

Source files
------------

// File: rtl/vme_master_arbiter.sv
// Round-robin arbiter sharing one VME master command port between two requesters.
// Issues a one-cycle command strobe, waits for completion and aborts on watchdog expiry.
module vme_master_arbiter #(
    parameter int TIMEOUT_CYC = 1023,
    parameter int TO_W        = 10
) (
    input  logic        clk,
    input  logic        sw_reset,
    input  logic        req_a,
    input  logic [23:1] addr_a,
    input  logic        wr_a,
    input  logic        rd_a,
    input  logic [15:0] wdata_a,
    output logic        grant_a,
    output logic        done_a,
    input  logic        req_b,
    input  logic [23:1] addr_b,
    input  logic        wr_b,
    input  logic        rd_b,
    input  logic [15:0] wdata_b,
    output logic        grant_b,
    output logic        done_b,
    output logic [15:0] rd_data,
    output logic        timeout_err,
    output logic        busy,
    output logic        spurious,
    output logic        vme_cmd,
    output logic [23:1] vme_addr,
    output logic        vme_wr,
    output logic        vme_rd,
    output logic [15:0] vme_wr_data,
    input  logic        vme_cmd_rd,
    input  logic [15:0] vme_rd_data
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] CNT_ONE  = TO_W'(1);

    state_t          state_q;
    logic [TO_W-1:0] cnt_q;
    logic            last_owner_q;   // 1'b1 = port B
    logic            owner_q;
    logic            grant_a_q, grant_b_q, done_a_q, done_b_q;
    logic [15:0]     rd_data_q;
    logic            timeout_err_q, busy_q, spurious_q, vme_cmd_q;
    logic [23:1]     vme_addr_q;
    logic            vme_wr_q, vme_rd_q;
    logic [15:0]     vme_wr_data_q;
    logic            pick_b_d;

    // Port choice in IDLE: a lone requester wins, a tie goes to the port that did not own last.
    always_comb begin
        pick_b_d = 1'b0;
        if (req_b && (!req_a || !last_owner_q)) begin
            pick_b_d = 1'b1;
        end else begin
            pick_b_d = 1'b0;
        end
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (sw_reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            last_owner_q  <= 1'b1;
            owner_q       <= 1'b0;
            grant_a_q     <= 1'b0;
            grant_b_q     <= 1'b0;
            done_a_q      <= 1'b0;
            done_b_q      <= 1'b0;
            rd_data_q     <= 16'h0000;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            spurious_q    <= 1'b0;
            vme_cmd_q     <= 1'b0;
            vme_addr_q    <= 23'h000000;
            vme_wr_q      <= 1'b0;
            vme_rd_q      <= 1'b0;
            vme_wr_data_q <= 16'h0000;
        end else begin
            vme_cmd_q <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            if (vme_cmd_rd && (state_q != S_WAIT)) begin
                spurious_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (req_a || req_b) begin
                        grant_a_q     <= !pick_b_d;
                        grant_b_q     <= pick_b_d;
                        owner_q       <= pick_b_d;
                        last_owner_q  <= pick_b_d;
                        vme_addr_q    <= pick_b_d ? addr_b  : addr_a;
                        vme_wr_q      <= pick_b_d ? wr_b    : wr_a;
                        vme_rd_q      <= pick_b_d ? rd_b    : rd_a;
                        vme_wr_data_q <= pick_b_d ? wdata_b : wdata_a;
                        busy_q        <= 1'b1;
                        state_q       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    vme_cmd_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion in the final watchdog cycle takes priority over the abort.
                    if (vme_cmd_rd) begin
                        if (vme_rd_q) begin
                            rd_data_q <= vme_rd_data;
                        end
                        timeout_err_q <= 1'b0;
                        done_a_q      <= !owner_q;
                        done_b_q      <= owner_q;
                        state_q       <= S_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        rd_data_q     <= 16'h0000;
                        timeout_err_q <= 1'b1;
                        done_a_q      <= !owner_q;
                        done_b_q      <= owner_q;
                        state_q       <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_DONE: begin
                    grant_a_q <= 1'b0;
                    grant_b_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    grant_a_q <= 1'b0;
                    grant_b_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign grant_a     = grant_a_q;
    assign grant_b     = grant_b_q;
    assign done_a      = done_a_q;
    assign done_b      = done_b_q;
    assign rd_data     = rd_data_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;
    assign spurious    = spurious_q;
    assign vme_cmd     = vme_cmd_q;
    assign vme_addr    = vme_addr_q;
    assign vme_wr      = vme_wr_q;
    assign vme_rd      = vme_rd_q;
    assign vme_wr_data = vme_wr_data_q;
endmodule

// File: tb/tb_vme_master_arbiter.sv
// Directed self-checking bench for vme_master_arbiter with an 8-cycle watchdog.
module tb_vme_master_arbiter;
    logic        clk = 1'b0;
    logic        sw_reset;
    logic        req_a, wr_a, rd_a, req_b, wr_b, rd_b;
    logic [23:1] addr_a, addr_b;
    logic [15:0] wdata_a, wdata_b;
    logic        grant_a, done_a, grant_b, done_b;
    logic [15:0] rd_data;
    logic        timeout_err, busy, spurious, vme_cmd, vme_wr, vme_rd;
    logic [23:1] vme_addr;
    logic [15:0] vme_wr_data;
    logic        vme_cmd_rd;
    logic [15:0] vme_rd_data;

    int n_checks = 0;
    int n_errors = 0;
    int gb_cnt   = 0;
    int gb_start;
    int lat;
    logic exp_b [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    vme_master_arbiter #(.TIMEOUT_CYC(8), .TO_W(4)) dut (
        .clk(clk), .sw_reset(sw_reset),
        .req_a(req_a), .addr_a(addr_a), .wr_a(wr_a), .rd_a(rd_a), .wdata_a(wdata_a),
        .grant_a(grant_a), .done_a(done_a),
        .req_b(req_b), .addr_b(addr_b), .wr_b(wr_b), .rd_b(rd_b), .wdata_b(wdata_b),
        .grant_b(grant_b), .done_b(done_b),
        .rd_data(rd_data), .timeout_err(timeout_err), .busy(busy), .spurious(spurious),
        .vme_cmd(vme_cmd), .vme_addr(vme_addr), .vme_wr(vme_wr), .vme_rd(vme_rd),
        .vme_wr_data(vme_wr_data), .vme_cmd_rd(vme_cmd_rd), .vme_rd_data(vme_rd_data)
    );

    always #5 clk = ~clk;

    // Count cycles in which port B holds the grant.
    always @(posedge clk) begin
        if (grant_b) gb_cnt <= gb_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cmd(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!vme_cmd && cycles < 20);
        chk("cmd_seen", 32'(vme_cmd), 32'd1);
    endtask

    // Master completion sampled 'delay' edges after the edge that raised vme_cmd.
    task automatic respond(input int delay, input logic [15:0] data);
        repeat (delay - 1) tick();
        vme_cmd_rd  = 1'b1;
        vme_rd_data = data;
        tick();
        vme_cmd_rd  = 1'b0;
        vme_rd_data = 16'h0000;
    endtask

    initial begin
        sw_reset = 1'b1;
        req_a = 1'b0; wr_a = 1'b0; rd_a = 1'b0; addr_a = 23'h0; wdata_a = 16'h0;
        req_b = 1'b0; wr_b = 1'b0; rd_b = 1'b0; addr_b = 23'h0; wdata_b = 16'h0;
        vme_cmd_rd = 1'b0; vme_rd_data = 16'h0000;
        tick(); tick();
        sw_reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grants", 32'({grant_a, grant_b}), 32'd0);
        chk("rst_cmd", 32'(vme_cmd), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_spurious", 32'(spurious), 32'd0);

        // Both ports write continuously: A, B, A, B.
        req_a = 1'b1; wr_a = 1'b1; addr_a = 23'h000100; wdata_a = 16'hA000;
        req_b = 1'b1; wr_b = 1'b1; addr_b = 23'h000200; wdata_b = 16'hB000;
        for (int t = 0; t < 4; t++) begin
            wait_cmd(lat);
            chk("rr_grant_b", 32'(grant_b), 32'(exp_b[t]));
            chk("rr_addr", 32'(vme_addr), exp_b[t] ? 32'h200 : 32'h100);
            chk("rr_wdata", 32'(vme_wr_data), exp_b[t] ? 32'hB000 : 32'hA000);
            respond(2, 16'h0000);
            chk("rr_done", 32'({done_a, done_b}), exp_b[t] ? 32'd1 : 32'd2);
            if (t == 3) begin
                req_a = 1'b0;
                req_b = 1'b0;
            end
        end
        tick(); tick();

        // Single A read.
        gb_start = gb_cnt;
        req_a = 1'b1; addr_a = 23'h007000; rd_a = 1'b1; wr_a = 1'b0;
        wait_cmd(lat);
        chk("a_lat", 32'(lat), 32'd2);
        chk("a_addr", 32'(vme_addr), 32'h7000);
        chk("a_flags", 32'({vme_wr, vme_rd}), 32'd1);
        chk("a_grant", 32'(grant_a), 32'd1);
        tick();
        chk("a_cmd_1cyc", 32'(vme_cmd), 32'd0);
        respond(4, 16'hBEEF);
        chk("a_done", 32'(done_a), 32'd1);
        chk("a_rd_data", 32'(rd_data), 32'hBEEF);
        chk("a_to_err", 32'(timeout_err), 32'd0);
        req_a = 1'b0;
        tick();
        chk("a_done_1cyc", 32'(done_a), 32'd0);
        chk("a_grant_drop", 32'(grant_a), 32'd0);
        chk("a_idle", 32'(busy), 32'd0);
        chk("a_no_grant_b", 32'(gb_cnt - gb_start), 32'd0);

        // Second contention round: A owned last, so B goes first.
        wr_a = 1'b1; rd_a = 1'b0;
        req_a = 1'b1; req_b = 1'b1;
        wait_cmd(lat);
        chk("c2_first_b", 32'({grant_a, grant_b}), 32'd1);
        respond(2, 16'h0000);
        chk("c2_done_b", 32'(done_b), 32'd1);
        req_b = 1'b0;
        wait_cmd(lat);
        chk("c2_then_a", 32'({grant_a, grant_b}), 32'd2);
        respond(2, 16'h0000);
        chk("c2_done_a", 32'(done_a), 32'd1);
        req_a = 1'b0;
        tick();

        // Watchdog abort after 8 WAIT cycles.
        req_a = 1'b1; rd_a = 1'b1; wr_a = 1'b0;
        wait_cmd(lat);
        repeat (7) tick();
        chk("to_early", 32'(done_a), 32'd0);
        tick();
        chk("to_done", 32'(done_a), 32'd1);
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_rd_data", 32'(rd_data), 32'd0);
        req_a = 1'b0;
        req_b = 1'b1; wr_b = 1'b1; rd_b = 1'b0;
        wait_cmd(lat);
        respond(3, 16'hDEAD);
        chk("to_b_done", 32'(done_b), 32'd1);
        chk("to_b_err", 32'(timeout_err), 32'd0);
        chk("to_b_rd_hold", 32'(rd_data), 32'd0);
        req_b = 1'b0;
        tick();

        // Completion in the final watchdog cycle.
        req_a = 1'b1;
        wait_cmd(lat);
        respond(8, 16'h1234);
        chk("last_done", 32'(done_a), 32'd1);
        chk("last_err", 32'(timeout_err), 32'd0);
        chk("last_rd_data", 32'(rd_data), 32'h1234);
        req_a = 1'b0;
        tick();

        // Reset during WAIT.
        req_a = 1'b1;
        wait_cmd(lat);
        tick(); tick();
        sw_reset = 1'b1;
        req_a = 1'b0;
        tick();
        sw_reset = 1'b0;
        chk("wrst_grant", 32'(grant_a), 32'd0);
        chk("wrst_busy", 32'(busy), 32'd0);
        chk("wrst_rd_data", 32'(rd_data), 32'd0);
        chk("wrst_addr", 32'(vme_addr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wrst_no_done", 32'({done_a, done_b, vme_cmd}), 32'd0);
        end
        req_a = 1'b1; addr_a = 23'h000ABC;
        wait_cmd(lat);
        chk("wrst_lat", 32'(lat), 32'd2);
        respond(3, 16'h5A5A);
        chk("wrst_done", 32'(done_a), 32'd1);
        chk("wrst_rd_data2", 32'(rd_data), 32'h5A5A);
        req_a = 1'b0;
        tick(); tick();

        // Completion strobe while idle.
        chk("sp_clear", 32'(spurious), 32'd0);
        vme_cmd_rd = 1'b1; vme_rd_data = 16'hFFFF;
        tick();
        vme_cmd_rd = 1'b0; vme_rd_data = 16'h0000;
        chk("sp_set", 32'(spurious), 32'd1);
        chk("sp_idle", 32'(busy), 32'd0);
        chk("sp_rd_hold", 32'(rd_data), 32'h5A5A);
        chk("sp_no_done", 32'({done_a, done_b}), 32'd0);
        repeat (3) tick();
        chk("sp_sticky", 32'(spurious), 32'd1);
        sw_reset = 1'b1;
        tick();
        sw_reset = 1'b0;
        chk("sp_reset", 32'(spurious), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
